// File: rtl/dom_enc_pkg.sv
// Shared types and helpers for the 3-share DOM encoder: FSM state type,
// default word width and the slicing of the packed randomness word.
package dom_enc_pkg;

  typedef enum logic [1:0] {IDLE, RND, MIX, OUT} state_t;

  localparam int DEFAULT_W = 8;
  // Widest share the rnd slicing helpers support.
  localparam int MAX_W = 64;

  // r0 occupies the low w bits of the randomness word.
  function automatic logic [MAX_W-1:0] rnd_r0(input logic [2*MAX_W-1:0] data, input int w);
    logic [MAX_W-1:0] mask;
    mask = ~({MAX_W{1'b1}} << w);
    return MAX_W'(data & {{MAX_W{1'b0}}, mask});
  endfunction

  // r1 occupies the next w bits above r0.
  function automatic logic [MAX_W-1:0] rnd_r1(input logic [2*MAX_W-1:0] data, input int w);
    logic [MAX_W-1:0] mask;
    mask = ~({MAX_W{1'b1}} << w);
    return MAX_W'((data >> w) & {{MAX_W{1'b0}}, mask});
  endfunction

endpackage

// File: rtl/dom_share_encoder.sv
// Producer of 3-share DOM encodings: x -> (x^r0^r1, r0, r1), one mask per stage.
// Optional macro DOM_ENC_FLUSH_EN clears share/secret registers between words.
module dom_share_encoder
  import dom_enc_pkg::*;
#(
  parameter int W     = DEFAULT_W,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_data,
  input  logic               rnd_valid,
  output logic               rnd_ready,
  input  logic [2*W-1:0]     rnd_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       s0,
  output logic [W-1:0]       s1,
  output logic [W-1:0]       s2,
  output logic [CNT_W-1:0]   enc_cnt
);

`ifdef DOM_ENC_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  state_t       state;
  logic [W-1:0] x_q;
  logic [W-1:0] t_q;
  logic [W-1:0] r0;
  logic [W-1:0] r1;

  assign r0 = W'(rnd_r0((2*MAX_W)'(rnd_data), W));
  assign r1 = W'(rnd_r1((2*MAX_W)'(rnd_data), W));

  // NOTE: all state here is sequential, so every assignment is non-blocking;
  // the handshake outputs are registered from the next state so they stay Moore.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      rnd_ready <= 1'b0;
      out_valid <= 1'b0;
      x_q       <= '0;
      t_q       <= '0;
      s0        <= '0;
      s1        <= '0;
      s2        <= '0;
      enc_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_ready && in_valid) begin
            x_q       <= in_data;
            in_ready  <= 1'b0;
            rnd_ready <= 1'b1;
            state     <= RND;
          end
        end
        RND: begin
          if (rnd_valid) begin
            // x only ever meets r0 here; r1 joins one register stage later.
            t_q       <= x_q ^ r0;
            s1        <= r0;
            s2        <= r1;
            rnd_ready <= 1'b0;
            state     <= MIX;
            if (FLUSH) x_q <= '0;
          end
        end
        MIX: begin
          s0        <= t_q ^ s2;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            enc_cnt   <= enc_cnt + CNT_W'(1);
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
            if (FLUSH) begin
              s0  <= '0;
              s1  <= '0;
              s2  <= '0;
              x_q <= '0;
              t_q <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
